// File: rtl/seg_execute_muldiv.sv
// Iterative multiply/divide unit for the MIPS execute stage.
// Owns the architectural HI/LO registers. MULTU/MULT use radix-2 shift-add
// and DIVU/DIV use restoring division, one step per cycle. Signed operations
// work on magnitudes, and the signs are fixed up on the last step.
module seg_execute_muldiv #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 2,
    parameter int NB_CNT  = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic               i_wr_hi,
    input  logic               i_wr_lo,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_div_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_is_div;
    logic                 r_neg_q;     // quotient / product must be negated
    logic                 r_neg_r;     // remainder must be negated (dividend sign)
    logic                 r_dz;
    logic [NB_CNT-1:0]    r_cnt;
    logic [2*NB_DATA-1:0] r_acc;       // multiply: {partial, multiplier}; divide: {rem, quo}
    logic [NB_DATA-1:0]   r_opb;       // multiplicand or divisor magnitude
    logic [NB_DATA-1:0]   r_hi;
    logic [NB_DATA-1:0]   r_lo;

    // Operand conditioning at the start edge
    logic                 w_is_div;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [NB_DATA-1:0]   w_mag_a;
    logic [NB_DATA-1:0]   w_mag_b;
    logic                 w_div_zero;
    logic                 w_start;

    assign w_is_div   = i_op[1];
    assign w_sign_a   = i_op[0] & i_data_a[NB_DATA-1];
    assign w_sign_b   = i_op[0] & i_data_b[NB_DATA-1];
    assign w_mag_a    = w_sign_a ? -i_data_a : i_data_a;
    assign w_mag_b    = w_sign_b ? -i_data_b : i_data_b;
    assign w_div_zero = w_is_div && (i_data_b == '0);
    assign w_start    = (r_state == ST_IDLE) && i_start;

    // One iteration step for each algorithm
    logic [NB_DATA:0]     w_mul_sum;
    logic [2*NB_DATA-1:0] w_mul_next;
    logic [NB_DATA:0]     w_trial;
    logic [2*NB_DATA-1:0] w_div_next;
    logic [2*NB_DATA-1:0] w_acc_next;
    logic [2*NB_DATA-1:0] w_prod_fix;
    logic [NB_DATA-1:0]   w_res_hi;
    logic [NB_DATA-1:0]   w_res_lo;
    logic                 w_last;

    assign w_mul_sum  = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]}
                      + (r_acc[0] ? {1'b0, r_opb} : {(NB_DATA+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[NB_DATA-1:1]};
    // Trial subtract of the divisor from the remainder shifted left by one dividend bit
    assign w_trial    = {r_acc[2*NB_DATA-1:NB_DATA], r_acc[NB_DATA-1]} - {1'b0, r_opb};
    assign w_div_next = w_trial[NB_DATA] ? {r_acc[2*NB_DATA-2:0], 1'b0}
                                         : {w_trial[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b1};
    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;
    assign w_prod_fix = r_neg_q ? -w_acc_next : w_acc_next;
    assign w_res_hi   = r_is_div ? (r_neg_r ? -w_acc_next[2*NB_DATA-1:NB_DATA]
                                            : w_acc_next[2*NB_DATA-1:NB_DATA])
                                 : w_prod_fix[2*NB_DATA-1:NB_DATA];
    assign w_res_lo   = r_is_div ? (r_neg_q ? -w_acc_next[NB_DATA-1:0]
                                            : w_acc_next[NB_DATA-1:0])
                                 : w_prod_fix[NB_DATA-1:0];
    assign w_last     = (r_state == ST_CALC) && (r_cnt == NB_CNT'(1));

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_next = w_div_zero ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == NB_CNT'(1)) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        o_busy     = (r_state != ST_IDLE);
        o_done     = (r_state == ST_DONE);
        o_div_zero = (r_state == ST_DONE) && r_dz;
        o_hi       = r_hi;
        o_lo       = r_lo;
    end

    // Datapath: operand capture, iteration, result and MTHI/MTLO writes
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_start) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_dz     <= w_div_zero;
            r_cnt    <= NB_CNT'(NB_DATA);
            r_acc    <= {{NB_DATA{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_opb    <= w_is_div ? w_mag_b : w_mag_a;
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - NB_CNT'(1);
            if (w_last) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (r_state == ST_IDLE) begin
            if (i_wr_hi) r_hi <= i_wr_data;
            if (i_wr_lo) r_lo <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_seg_execute_muldiv.sv
// Self-checking bench for seg_execute_muldiv (NB_DATA=32): directed cases
// followed by random operations, compared against a plain-arithmetic model.
module tb_seg_execute_muldiv;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [N-1:0]  da = '0;
    logic [N-1:0]  db = '0;
    logic          wr_hi = 1'b0;
    logic          wr_lo = 1'b0;
    logic [N-1:0]  wr_data = '0;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic          busy;
    logic          done;
    logic          dz;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] m_hi = '0;
    logic [N-1:0] m_lo = '0;

    seg_execute_muldiv #(.NB_DATA(N), .NB_OP(2), .NB_CNT(6)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_op(op),
        .i_data_a(da), .i_data_b(db), .i_wr_hi(wr_hi), .i_wr_lo(wr_lo),
        .i_wr_data(wr_data), .o_hi(hi), .o_lo(lo), .o_busy(busy),
        .o_done(done), .o_div_zero(dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each operation, using 64-bit arithmetic
    task automatic model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] eh, output logic [N-1:0] el, output bit ez);
        logic [63:0] up;
        longint      sa, sb, sp, sq, sr;
        eh = m_hi; el = m_lo; ez = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin up = 64'(a) * 64'(b); eh = up[63:32]; el = up[31:0]; end
            2'd1: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
            2'd2: if (b == 0) ez = 1'b1; else begin el = a / b; eh = a % b; end
            default: if (b == 0) ez = 1'b1;
                     else begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; end
        endcase
    endtask

    // Issue one operation; optionally poke start/MT writes while busy, or MTLO with start
    task automatic run_op(input string tag, input logic [1:0] o, input logic [N-1:0] a,
                          input logic [N-1:0] b, input int poke, input bit wr_with_start);
        logic [N-1:0] eh, el;
        bit ez;
        int n;
        model(o, a, b, eh, el, ez);
        @(negedge clk);
        op = o; da = a; db = b; start = 1'b1;
        if (wr_with_start) begin wr_lo = 1'b1; wr_data = 32'h5555_5555; end
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        da = $urandom; db = $urandom; op = 2'($urandom_range(0, 3));
        n = 1;
        check({tag, "_busy1"}, 64'(busy), 64'd1);
        while (!done && n < 40) begin
            if (n == poke) begin
                start = 1'b1; op = 2'd3; da = 32'd99; db = 32'd0;
                wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            n++;
        end
        check({tag, "_latency"}, 64'(n), ez ? 64'd1 : 64'd33);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        check({tag, "_divzero"}, 64'(dz), 64'(ez));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        $display("op %s code=%0d a=0x%08h b=0x%08h hi=0x%08h lo=0x%08h dz=%0d cycles=%0d",
                 tag, o, a, b, hi, lo, dz, n);
        m_hi = eh; m_lo = el;
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_done_after"}, 64'(done), 64'd0);
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [N-1:0] d);
        @(negedge clk);
        wr_hi = h; wr_lo = l; wr_data = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
        $display("mt wr_hi=%0d wr_lo=%0d data=0x%08h hi=0x%08h lo=0x%08h", h, l, d, hi, lo);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [N-1:0] ra, rb;

        // Reset state
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(dz), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check("multu_max_hi_const", 64'(m_hi), 64'h0000_0000_FFFF_FFFE);
        run_op("mult_neg3x5", 2'd1, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
        run_op("div_m7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 0, 1'b0);
        run_op("div_minneg", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        mt_write(1'b1, 1'b0, 32'h0000_AAAA);
        run_op("divu_by0", 2'd2, 32'd100, 32'd0, 0, 1'b0);
        run_op("div_by0", 2'd3, 32'hFFFF_0000, 32'd0, 0, 1'b0);
        mt_write(1'b1, 1'b1, 32'h1234_5678);
        run_op("multu_poke", 2'd0, 32'd3, 32'd4, 5, 1'b0);
        run_op("multu_wr_start", 2'd0, 32'd5, 32'd6, 0, 1'b1);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op = 2'd2; da = 32'd1000; db = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_dz", 64'(dz), 64'd0);
        $display("async reset mid-divide hi=0x%08h lo=0x%08h busy=%0d", hi, lo, busy);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("multu_6x7", 2'd0, 32'd6, 32'd7, 0, 1'b0);

        // Random operations, with a bias toward corner operands
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), ro, ra, rb, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_execute_muldiv.md
Name: seg_execute_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the execute stage of the MIPS pipeline. It sits beside seg_execute_alu.
- Implements MULTU, MULT, DIVU and DIV as multi-cycle operations and writes results into architectural HI/LO registers.
- Provides MTHI/MTLO write ports and a start/busy/done handshake so the hazard unit can stall MFHI/MFLO while an operation is in flight.

Parameters:
- NB_DATA, 32, operand and HI/LO width; legal range 4..64.
- NB_OP, 2, operation select width.
- NB_CNT, 6, iteration counter width; must satisfy 2^NB_CNT > NB_DATA.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  request an operation; sampled only in IDLE.
- i_op  in  NB_OP  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- i_data_a  in  NB_DATA  rs operand (multiplicand / dividend).
- i_data_b  in  NB_DATA  rt operand (multiplier / divisor).
- i_wr_hi  in  1  MTHI strobe.
- i_wr_lo  in  1  MTLO strobe.
- i_wr_data  in  NB_DATA  MTHI/MTLO data.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.
- o_busy  out  1  high when state is not IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_div_zero  out  1  high with o_done when a divide had divisor 0.

Behaviour:
- Reset (i_reset=0, asynchronous, any time including mid-operation):
  - state=IDLE; o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_zero=0.
  - Internal accumulators and counter are cleared.
  - Any in-flight operation is discarded.
- States and transitions:
  - IDLE -> CALC when i_start=1.
  - CALC -> DONE after NB_DATA iterations.
  - IDLE -> DONE directly when i_start=1 for a divide with i_data_b=0.
  - DONE -> IDLE unconditionally after one cycle.
- Start sampling:
  - On the start edge, latch i_op, operand magnitudes and sign flags, and load the counter with NB_DATA.
  - Operands may change freely after the start edge.
- Signed vs unsigned operands:
  - Signed ops (MULT, DIV): take two's-complement magnitudes of the operands.
  - Unsigned ops: use the operands as-is.
- CALC, one iteration per cycle, counter decrements each cycle:
  - Multiply: radix-2 shift-add over a 2*NB_DATA-bit product.
  - Divide: restoring, one quotient bit per cycle.
- Latency:
  - Start edge at cycle 0; o_busy=1 in cycles 1..NB_DATA+1.
  - o_done=1 only in cycle NB_DATA+1; o_busy falls in cycle NB_DATA+2.
  - A new i_start is accepted in cycle NB_DATA+2 at the earliest.
- Result write: HI/LO are written on the edge entering DONE and are valid while o_done=1.
  - Multiply: {HI,LO} = full 2*NB_DATA-bit product. For MULT, the product is negated if the operand signs differ.
  - Divide: LO = quotient, HI = remainder.
  - DIV sign rules: quotient negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - DIV of most-negative by -1: LO = most-negative (wraps), HI = 0, no flag.
- Divide by zero:
  - The unit enters DONE one cycle after start, so o_done is in cycle 1.
  - o_div_zero=1 in that same cycle; HI/LO are unchanged.
- i_start while o_busy=1 is ignored; there is no queuing.
- MTHI/MTLO:
  - In IDLE with i_start=0, i_wr_hi/i_wr_lo write i_wr_data to HI/LO on the next edge; both strobes may be asserted together.
  - In IDLE, if i_start=1 in the same cycle, the start wins and the writes are dropped.
  - While busy, the writes are ignored.
- Outputs are registered: no combinational path from inputs to outputs.

Test Plan:
- NB_DATA=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> o_done exactly 33 cycles after start; HI=0xFFFFFFFE, LO=0x00000001; o_busy=1 for cycles 1..33.
- MULT a=0xFFFFFFFD (-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0xAAAA via MTHI; DIVU 100/0 -> o_done and o_div_zero in cycle 1; HI=0xAAAA, LO unchanged.
- Pulse i_start with new operands at cycle 5 of a MULTU 3*4 -> ignored; result HI=0, LO=12. MTLO during busy -> ignored. MTLO+start in the same IDLE cycle -> start wins.
- Drop i_reset low at cycle 10 of a DIVU -> outputs 0 immediately without a clock edge. After release, MULTU 6*7 completes normally with LO=42.
